// File: rtl/imem_boot_loader.sv
// Boot loader: streams program words into instruction memory, then releases the core.
// Optional BOOT_CHECKSUM_EN adds a trailing checksum beat verified before release.
module imem_boot_loader #(
    parameter int DEPTH         = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [31:0]            imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_rst,
    output logic                   done,
    output logic [$clog2(DEPTH):0] word_count,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH) + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD, CHECK, SETTLE, RUN, ERROR} state_t;
    logic [31:0] csum;
`else
    typedef enum logic [2:0] {LOAD, SETTLE, RUN, ERROR} state_t;
`endif

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          full;

    assign full = (word_count == AW'(DEPTH));

    // A full memory deasserts ready so the overflowing beat is never taken.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                LOAD:    in_ready = !full;
`ifdef BOOT_CHECKSUM_EN
                CHECK:   in_ready = 1'b1;
`endif
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            word_count <= '0;
            settle_cnt <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (full) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= 32'({word_count, 2'b00});
                            imem_wdata <= in_data;
                            word_count <= word_count + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            csum       <= csum + in_data;
                            if (in_last) state <= CHECK;
`else
                            if (in_last) begin
                                state      <= SETTLE;
                                settle_cnt <= '0;
                            end
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (in_valid) begin
                        if (in_data == csum) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: a 64-deep loader for the main flows, a 4-deep one for the capacity edge.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // 64-deep instance
    logic        a_rst, a_valid, a_ready, a_last, a_we, a_crst, a_done, a_err;
    logic [31:0] a_data, a_addr, a_wdata;
    logic [6:0]  a_wc;

    // 4-deep instance
    logic        b_rst, b_valid, b_ready, b_last, b_we, b_crst, b_done, b_err;
    logic [31:0] b_data, b_addr, b_wdata;
    logic [2:0]  b_wc;

    imem_boot_loader #(.DEPTH(64), .SETTLE_CYCLES(2)) u64 (
        .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_last(a_last), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_rst(a_crst), .done(a_done), .word_count(a_wc), .err(a_err));

    imem_boot_loader #(.DEPTH(4), .SETTLE_CYCLES(2)) u4 (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_last(b_last), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_rst(b_crst), .done(b_done), .word_count(b_wc), .err(b_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic v, input logic [31:0] d, input logic l);
        a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] d, input logic l);
        b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        a_drive(1'b0, 32'h0, 1'b0);
        tick();
        a_rst = 1'b0;
    endtask

    task automatic b_reset();
        b_rst = 1'b1;
        b_drive(1'b0, 32'h0, 1'b0);
        tick();
        b_rst = 1'b0;
    endtask

    task automatic a_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, " we"},    32'(a_we), 32'd1);
        check({tag, " addr"},  a_addr,    addr);
        check({tag, " wdata"}, a_wdata,   data);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_drive(1'b1, 32'hDEADBEEF, 1'b0);
        b_drive(1'b1, 32'hDEADBEEF, 1'b0);
        #1;
        check("rst ready comb", 32'(a_ready), 32'd0);
        tick();
        check("rst ready",    32'(a_ready), 32'd0);
        check("rst wc",       32'(a_wc),    32'd0);
        check("rst we",       32'(a_we),    32'd0);
        check("rst addr",     a_addr,       32'd0);
        check("rst wdata",    a_wdata,      32'd0);
        check("rst core_rst", 32'(a_crst),  32'd1);
        check("rst done",     32'(a_done),  32'd0);
        check("rst err",      32'(a_err),   32'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        a_drive(1'b0, 32'h0, 1'b0);
        b_drive(1'b0, 32'h0, 1'b0);

`ifndef BOOT_CHECKSUM_EN
        // Back-to-back load, beats accepted at cycles 0..2
        a_drive(1'b1, 32'h00500093, 1'b0);
        #1 check("b2b ready", 32'(a_ready), 32'd1);
        tick();
        a_write("b2b w0", 32'h0, 32'h00500093);
        a_drive(1'b1, 32'h00500113, 1'b0);
        tick();
        a_write("b2b w1", 32'h4, 32'h00500113);
        a_drive(1'b1, 32'h00208463, 1'b1);
        tick();
        a_write("b2b w2", 32'h8, 32'h00208463);
        check("b2b wc", 32'(a_wc), 32'd3);
        check("b2b settle ready", 32'(a_ready), 32'd0);
        a_drive(1'b0, 32'h0, 1'b0);
        tick();
        check("b2b c4 we", 32'(a_we), 32'd0);
        check("b2b c4 core_rst", 32'(a_crst), 32'd1);
        check("b2b c4 done", 32'(a_done), 32'd0);
        tick();
        check("b2b c5 core_rst", 32'(a_crst), 32'd0);
        check("b2b c5 done", 32'(a_done), 32'd1);
        check("b2b c5 err", 32'(a_err), 32'd0);
        a_drive(1'b1, 32'h12345678, 1'b0);
        #1 check("run ready", 32'(a_ready), 32'd0);
        tick();
        check("run ignore we", 32'(a_we), 32'd0);
        check("run ignore wc", 32'(a_wc), 32'd3);
        check("run stays", 32'(a_done), 32'd1);

        // Same load with a two-cycle gap after the first word
        a_reset();
        a_drive(1'b1, 32'h00500093, 1'b0);
        tick();
        a_write("gap w0", 32'h0, 32'h00500093);
        a_drive(1'b0, 32'hFFFFFFFF, 1'b1);
        tick();
        check("gap1 we", 32'(a_we), 32'd0);
        tick();
        check("gap2 we", 32'(a_we), 32'd0);
        check("gap wc", 32'(a_wc), 32'd1);
        a_drive(1'b1, 32'h00500113, 1'b0);
        tick();
        a_write("gap w1", 32'h4, 32'h00500113);
        a_drive(1'b1, 32'h00208463, 1'b1);
        tick();
        a_write("gap w2", 32'h8, 32'h00208463);
        a_drive(1'b0, 32'h0, 1'b0);
        tick();
        check("gap post we", 32'(a_we), 32'd0);
        check("gap wc end", 32'(a_wc), 32'd3);

        // Last beat exactly filling a 4-deep memory is legal
        b_reset();
        for (int i = 0; i < 4; i++) begin
            b_drive(1'b1, 32'hA0 + 32'(i), i == 3);
            tick();
            check("fit we", 32'(b_we), 32'd1);
            check("fit addr", b_addr, 32'(4 * i));
        end
        b_drive(1'b0, 32'h0, 1'b0);
        check("fit err", 32'(b_err), 32'd0);
        check("fit wc", 32'(b_wc), 32'd4);
        tick();
        check("fit settle done", 32'(b_done), 32'd0);
        tick();
        check("fit done", 32'(b_done), 32'd1);
        check("fit core_rst", 32'(b_crst), 32'd0);
`else
        // Checksum match: 1 + 2 + 3 = 6
        a_reset();
        for (int i = 1; i <= 3; i++) begin
            a_drive(1'b1, 32'(i), i == 3);
            tick();
            a_write("cs ok w", 32'(4 * (i - 1)), 32'(i));
        end
        a_drive(1'b1, 32'h6, 1'b0);
        #1 check("cs check ready", 32'(a_ready), 32'd1);
        tick();
        check("cs not written", 32'(a_we), 32'd0);
        check("cs wc", 32'(a_wc), 32'd3);
        a_drive(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        check("cs ok done", 32'(a_done), 32'd1);
        check("cs ok core_rst", 32'(a_crst), 32'd0);
        check("cs ok err", 32'(a_err), 32'd0);

        // Checksum mismatch
        a_reset();
        for (int i = 1; i <= 3; i++) begin
            a_drive(1'b1, 32'(i), i == 3);
            tick();
        end
        a_drive(1'b1, 32'h7, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 1'b0);
        check("cs bad err", 32'(a_err), 32'd1);
        check("cs bad we", 32'(a_we), 32'd0);
        tick();
        tick();
        tick();
        check("cs bad core_rst", 32'(a_crst), 32'd1);
        check("cs bad done", 32'(a_done), 32'd0);
`endif

        // Overflow on a 4-deep memory: fifth word refused
        b_reset();
        for (int i = 0; i < 4; i++) begin
            b_drive(1'b1, 32'hB0 + 32'(i), 1'b0);
            tick();
            check("ovf we", 32'(b_we), 32'd1);
            check("ovf addr", b_addr, 32'(4 * i));
        end
        b_drive(1'b1, 32'hB4, 1'b0);
        #1 check("ovf ready", 32'(b_ready), 32'd0);
        tick();
        check("ovf no write", 32'(b_we), 32'd0);
        check("ovf err", 32'(b_err), 32'd1);
        check("ovf wc", 32'(b_wc), 32'd4);
        check("ovf core_rst", 32'(b_crst), 32'd1);
        check("ovf done", 32'(b_done), 32'd0);
        b_drive(1'b1, 32'hB5, 1'b1);
        #1 check("err ready", 32'(b_ready), 32'd0);
        tick();
        check("err sticky", 32'(b_err), 32'd1);
        check("err no write", 32'(b_we), 32'd0);
        b_drive(1'b0, 32'h0, 1'b0);

        // Reset mid-load abandons progress
        a_reset();
        a_drive(1'b1, 32'h11, 1'b0);
        tick();
        a_drive(1'b1, 32'h22, 1'b0);
        tick();
        check("mid wc", 32'(a_wc), 32'd2);
        a_rst = 1'b1;
        a_drive(1'b0, 32'h0, 1'b0);
        tick();
        a_rst = 1'b0;
        check("mid rst wc", 32'(a_wc), 32'd0);
        check("mid rst err", 32'(a_err), 32'd0);
        check("mid rst we", 32'(a_we), 32'd0);
        a_drive(1'b1, 32'h33, 1'b0);
        tick();
        a_write("mid reload", 32'h0, 32'h33);
        a_drive(1'b0, 32'h0, 1'b0);

        // Reset out of ERROR restores a clean load
        b_reset();
        check("err clear", 32'(b_err), 32'd0);
        check("err clear wc", 32'(b_wc), 32'd0);
        check("err clear crst", 32'(b_crst), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64: instruction-memory capacity in 32-bit words (power of two, minimum 4).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2: number of cycles core_rst is held after the final accepted beat (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream program word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the loader accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, 32 bits: the program word.
REQ-008 The block SHALL have port in_last, input, 1 bit: marks the final program word.
REQ-009 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: byte write address, always word-aligned.
REQ-011 The block SHALL have port imem_wdata, output, 32 bits: write data.
REQ-012 The block SHALL have port core_rst, output, 1 bit: reset driven to the single-cycle core.
REQ-013 The block SHALL have port done, output, 1 bit: the program is loaded and the core is released.
REQ-014 The block SHALL have port word_count, output, log2(DEPTH)+1 bits: number of words accepted.
REQ-015 The block SHALL have port err, output, 1 bit: sticky load error.

Function
REQ-016 The FSM SHALL have states LOAD, CHECK (only when the macro is defined), SETTLE, RUN and ERROR.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 only in LOAD (and in CHECK), and 0 in all other states.
REQ-018 An accepted LOAD beat SHALL produce, one cycle later, imem_we=1, imem_addr=4*word_count (pre-increment value) and imem_wdata=in_data; imem_we SHALL be 0 in every other cycle.
REQ-019 word_count SHALL increment by 1 per accepted LOAD beat; cycles with in_valid=0 SHALL cause no write and no count change.
REQ-020 Acceptance of an in_last beat SHALL move LOAD to SETTLE on the next cycle (or to CHECK when the macro is defined).
REQ-021 If in_valid=1 in LOAD while word_count==DEPTH, the beat SHALL NOT be written, in_ready SHALL be 0 for that beat, and the next state SHALL be ERROR.
REQ-022 An in_last beat arriving at word_count==DEPTH-1 SHALL be accepted normally; it is not an overflow.
REQ-023 The block SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then enter RUN.
REQ-024 core_rst SHALL be 1 in LOAD, CHECK, SETTLE and ERROR, and 0 only in RUN.
REQ-025 done SHALL be 1 only in RUN.
REQ-026 err SHALL be 1 only in ERROR.
REQ-027 RUN and ERROR SHALL be terminal until rst; input beats in those states SHALL be ignored.
REQ-028 Latency: with the last beat accepted at cycle k, done SHALL rise and core_rst SHALL fall at cycle k+1+SETTLE_CYCLES.

Reset
REQ-029 While rst=1, the block SHALL enter LOAD with word_count=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0 and err=0; in_ready SHALL be 0 during the rst cycle.
REQ-030 Reset asserted mid-load, in SETTLE, in RUN or in ERROR SHALL abandon all progress; the next load SHALL start writing at address 0.

Configuration
REQ-031 When BOOT_CHECKSUM_EN is defined, the block SHALL keep csum, the sum modulo 2^32 of all accepted LOAD words, cleared on reset.
REQ-032 When BOOT_CHECKSUM_EN is defined, after in_last the block SHALL enter CHECK and accept exactly one further beat as the expected checksum, which SHALL NOT be written to memory.
REQ-033 In CHECK, a match SHALL lead to SETTLE and a mismatch SHALL lead to ERROR.
REQ-034 When BOOT_CHECKSUM_EN is undefined, the block SHALL have no CHECK state and no csum logic, and in_last SHALL lead directly to SETTLE.

Verification
REQ-035 The bench SHALL cover: DEPTH=64, SETTLE_CYCLES=2, back-to-back words 0x00500093, 0x00500113, 0x00208463 (last) accepted at cycles 0..2 -> writes at addresses 0x0, 0x4, 0x8 in cycles 1..3; word_count=3; core_rst falls and done rises at cycle 5.
REQ-036 The bench SHALL cover: the same three words with a 2-cycle in_valid gap after word 1 -> exactly 3 writes at addresses 0x0, 0x4, 0x8, and no write during the gap.
REQ-037 The bench SHALL cover: DEPTH=4, 5 words with no in_last -> 4 writes at addresses 0x0..0xC, fifth word not written, err=1, in_ready=0, core_rst stays 1 and done stays 0.
REQ-038 The bench SHALL cover: DEPTH=4, 4th word carrying in_last -> no error; done=1 after SETTLE_CYCLES.
REQ-039 The bench SHALL cover: rst pulsed for one cycle after 2 words accepted -> word_count=0 and err=0; the next accepted word is written at address 0x0.
REQ-040 The bench SHALL cover, with BOOT_CHECKSUM_EN defined: words 1, 2, 3 (last) then checksum 0x6 -> RUN; the same load with checksum 0x7 -> ERROR, err=1, core_rst stays 1.
